// File: rtl/sap_ext_mem_responder.sv
// Memory-side responder for the SAP-3 external memory pins: registered bus/strobe
// capture, MAR, byte RAM with write-first read-back, and a valid/ready preload port.
module sap_ext_mem_responder #(
  parameter int          ADDR_W   = 8,
  parameter logic [7:0]  OOB_DATA = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        bus_lo,
  input  logic [7:0]        bus_hi,
  input  logic              mar_we,
  input  logic              ram_we,
  output logic [7:0]        mem_out,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic [15:0]       mar_dbg,
  output logic              oob_err,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]        ram [DEPTH];
  logic [7:0]        bus_lo_q;
  logic [7:0]        bus_hi_q;
  logic              mar_we_q;
  logic              ram_we_q;
  logic [15:0]       mar;
  logic [15:0]       bus_q;
  logic [ADDR_W-1:0] mar_idx;
  logic              mar_oob;
  logic              new_oob;
  logic              core_wr;
  logic              ld_fire;
  logic [7:0]        rd_data;

  function automatic logic out_of_range(input logic [15:0] a);
    return (a >> ADDR_W) != 16'd0;
  endfunction

  assign bus_q   = {bus_hi_q, bus_lo_q};
  assign mar_idx = mar[ADDR_W-1:0];
  assign mar_oob = out_of_range(mar);
  assign new_oob = out_of_range(bus_q);
  assign core_wr = ram_we_q & ~mar_oob;

  // Preload handshake: a transfer happens on any edge where ld_valid && ld_ready.
  // ld_ready tracks ~ram_we_q, so any core write cycle (committed or dropped)
  // stalls the preload, and the requester must hold ld_addr/ld_data meanwhile.
  assign ld_fire = ld_valid & ld_ready;

  // Read mux with write-first bypass so a write to the current MAR is visible
  // in mem_out on the same edge that commits it.
  always_comb begin
    rd_data = ram[mar_idx];
    if (mar_oob) begin
      rd_data = OOB_DATA;
    end else if (core_wr) begin
      rd_data = bus_lo_q;
    end else if (ld_fire && (ld_addr == mar_idx)) begin
      rd_data = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (core_wr) begin
      ram[mar_idx] <= bus_lo_q;
    end else if (ld_fire) begin
      ram[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_lo_q <= 8'h00;
      bus_hi_q <= 8'h00;
      mar_we_q <= 1'b0;
      ram_we_q <= 1'b0;
      ld_ready <= 1'b0;
      mar      <= 16'h0000;
      mem_out  <= 8'h00;
      oob_err  <= 1'b0;
      wr_count <= 16'h0000;
    end else begin
      bus_lo_q <= bus_lo;
      bus_hi_q <= bus_hi;
      mar_we_q <= mar_we;
      ram_we_q <= ram_we;
      ld_ready <= ~ram_we;
      mem_out  <= rd_data;
      if (mar_we_q) begin
        mar <= bus_q;
      end
      if ((mar_we_q && new_oob) || (ram_we_q && mar_oob)) begin
        oob_err <= 1'b1;
      end
      if (core_wr && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  assign mar_dbg = mar;

endmodule

// File: tb/tb_sap_ext_mem_responder.sv
// Directed bench for sap_ext_mem_responder: preload, MAR/read latency, core writes,
// out-of-range handling, preload stall and asynchronous reset.
module tb_sap_ext_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  bus_lo;
  logic [7:0]  bus_hi;
  logic        mar_we;
  logic        ram_we;
  logic [7:0]  mem_out;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [15:0] mar_dbg;
  logic        oob_err;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  sap_ext_mem_responder #(.ADDR_W(8), .OOB_DATA(8'h00)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_lo   (bus_lo),
    .bus_hi   (bus_hi),
    .mar_we   (mar_we),
    .ram_we   (ram_we),
    .mem_out  (mem_out),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .mar_dbg  (mar_dbg),
    .oob_err  (oob_err),
    .wr_count (wr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe pulse; returns just after the edge that samples it.
  task automatic drive(input logic mw, input logic rw, input logic [15:0] b);
    mar_we = mw;
    ram_we = rw;
    {bus_hi, bus_lo} = b;
    tick();
    mar_we = 1'b0;
    ram_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bus_lo = 8'h00; bus_hi = 8'h00; mar_we = 1'b0; ram_we = 1'b0;
    ld_valid = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
    #3;
    chk("rst_mem_out", {8'h00, mem_out}, 16'h0000);
    chk("rst_mar", mar_dbg, 16'h0000);
    chk("rst_oob", {15'd0, oob_err}, 16'h0000);
    chk("rst_wr_count", wr_count, 16'h0000);
    chk("rst_ld_ready", {15'd0, ld_ready}, 16'h0000);
    tick();
    rst_n = 1'b1;
    chk("ld_ready_before_clk", {15'd0, ld_ready}, 16'h0000);
    tick();
    chk("ld_ready_after_clk", {15'd0, ld_ready}, 16'h0001);

    // Back-to-back preloads with ld_valid held high
    ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 8'h3E;
    chk("pre0_ready", {15'd0, ld_ready}, 16'h0001);
    tick();
    ld_addr = 8'h01; ld_data = 8'h05;
    chk("pre1_ready", {15'd0, ld_ready}, 16'h0001);
    tick();
    ld_addr = 8'h20; ld_data = 8'h77;
    tick();
    ld_valid = 1'b0;

    // MAR load latency: mem_out follows two edges after the strobe is sampled
    drive(1'b1, 1'b0, 16'h0001);
    tick();
    chk("mar_1", mar_dbg, 16'h0001);
    chk("mem_old_mar0", {8'h00, mem_out}, 16'h003E);
    tick();
    chk("mem_mar1", {8'h00, mem_out}, 16'h0005);

    // Core write to MAR=0x10, write-first read-back
    drive(1'b1, 1'b0, 16'h0010);
    tick();
    tick();
    drive(1'b0, 1'b1, 16'h00A5);
    chk("ld_ready_stall", {15'd0, ld_ready}, 16'h0000);
    tick();
    chk("wr_mem_a5", {8'h00, mem_out}, 16'h00A5);
    chk("wr_count_1", wr_count, 16'h0001);
    chk("ld_ready_back", {15'd0, ld_ready}, 16'h0001);

    // Simultaneous MAR load and write: write uses old MAR 0x10, data = bus_lo 0x20
    drive(1'b1, 1'b1, 16'h0020);
    tick();
    chk("sim_mar", mar_dbg, 16'h0020);
    chk("sim_wr_count", wr_count, 16'h0002);
    chk("sim_mem_bypass", {8'h00, mem_out}, 16'h0020);
    tick();
    chk("sim_ram20_kept", {8'h00, mem_out}, 16'h0077);
    drive(1'b1, 1'b0, 16'h0010);
    tick();
    tick();
    chk("sim_ram10_new", {8'h00, mem_out}, 16'h0020);

    // Out-of-range MAR
    chk("oob_clear", {15'd0, oob_err}, 16'h0000);
    drive(1'b1, 1'b0, 16'h0100);
    tick();
    chk("oob_set", {15'd0, oob_err}, 16'h0001);
    tick();
    chk("oob_mem", {8'h00, mem_out}, 16'h0000);
    drive(1'b0, 1'b1, 16'h00EE);
    tick();
    chk("oob_wr_dropped", wr_count, 16'h0002);
    drive(1'b1, 1'b0, 16'h0000);
    tick();
    tick();
    chk("oob_ram0_intact", {8'h00, mem_out}, 16'h003E);
    drive(1'b1, 1'b0, 16'h0005);
    tick();
    chk("oob_mar5", mar_dbg, 16'h0005);
    chk("oob_sticky", {15'd0, oob_err}, 16'h0001);

    // Preload stalled by a one-cycle core write to MAR=5
    drive(1'b0, 1'b1, 16'h00C3);
    ld_valid = 1'b1; ld_addr = 8'h30; ld_data = 8'h5A;
    chk("stall_ready_low", {15'd0, ld_ready}, 16'h0000);
    tick();
    chk("stall_ready_high", {15'd0, ld_ready}, 16'h0001);
    chk("stall_wr_count", wr_count, 16'h0003);
    chk("stall_core_mem", {8'h00, mem_out}, 16'h00C3);
    tick();
    ld_valid = 1'b0;
    drive(1'b1, 1'b0, 16'h0030);
    tick();
    tick();
    chk("stall_pre_data", {8'h00, mem_out}, 16'h005A);

    // Preload to the current MAR updates mem_out on the next edge
    ld_valid = 1'b1; ld_addr = 8'h30; ld_data = 8'h99;
    tick();
    ld_valid = 1'b0;
    chk("pre_bypass", {8'h00, mem_out}, 16'h0099);

    // Asynchronous reset mid-preload with a MAR strobe in flight
    drive(1'b1, 1'b0, 16'h0010);
    ld_valid = 1'b1; ld_addr = 8'h40; ld_data = 8'h11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_out", {8'h00, mem_out}, 16'h0000);
    chk("arst_mar", mar_dbg, 16'h0000);
    chk("arst_wr_count", wr_count, 16'h0000);
    chk("arst_oob", {15'd0, oob_err}, 16'h0000);
    chk("arst_ld_ready", {15'd0, ld_ready}, 16'h0000);
    tick();
    ld_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ram0", {8'h00, mem_out}, 16'h003E);
    drive(1'b1, 1'b0, 16'h0005);
    tick();
    tick();
    chk("post_rst_ram5", {8'h00, mem_out}, 16'h00C3);
    drive(1'b1, 1'b0, 16'h0030);
    tick();
    tick();
    chk("post_rst_ram30", {8'h00, mem_out}, 16'h0099);
    chk("post_rst_wr_count", wr_count, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
